// File: rtl/bloons_pkg.sv
// Shared bloon-track definitions used by the path walker, life_counter and the renderer.
package bloons_pkg;

  localparam int unsigned NUM_BLOONS = 32;
  localparam int unsigned PATH_LEN   = 640;
  localparam int unsigned POS_W      = 10;

  typedef enum logic [0:0] {IDLE, SWEEP} walker_state_t;

  typedef logic [4:0] slot_idx_t;

endpackage

// File: rtl/free_slot_encoder.sv
// Lowest-index free slot finder: priority encoder over the inverted occupancy vector.
module free_slot_encoder import bloons_pkg::*; #(
  parameter int unsigned NumSlots = NUM_BLOONS
) (
  input  logic      bloon_active [NumSlots],
  output slot_idx_t spawn_slot,
  output logic      any_free
);

  always_comb begin
    spawn_slot = '0;
    any_free   = 1'b0;
    // Walk downwards so the lowest free index is the last one written.
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!bloon_active[i]) begin
        spawn_slot = slot_idx_t'(i);
        any_free   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bloon_path_walker.sv
// Owns the bloon slots, advances them one slot per cycle on each movement tick and
// serialises track exits into one-hot lost_life pulses.
module bloon_path_walker import bloons_pkg::*; #(
  parameter int unsigned NumSlots = NUM_BLOONS,
  parameter int unsigned PathLen  = PATH_LEN,
  parameter int unsigned PosW     = POS_W
) (
  input  logic            Clk,
  input  logic            reset,
  input  logic            move_tick,
  input  logic            spawn_valid,
  output logic            spawn_ready,
  output slot_idx_t       spawn_slot,
  input  logic            pop          [NumSlots],
  output logic            lost_life    [NumSlots],
  output logic            bloon_active [NumSlots],
  output logic [PosW-1:0] bloon_pos    [NumSlots],
  output logic            busy
);

  localparam logic [PosW-1:0] ExitPos = PosW'(PathLen - 1);
  localparam slot_idx_t       LastIdx = slot_idx_t'(NumSlots - 1);

  walker_state_t state;
  slot_idx_t     idx;
  logic          pending;
  logic          any_free;

  free_slot_encoder #(
    .NumSlots(NumSlots)
  ) u_free_slot_encoder (
    .bloon_active(bloon_active),
    .spawn_slot  (spawn_slot),
    .any_free    (any_free)
  );

  assign busy        = (state == SWEEP);
  assign spawn_ready = (state == IDLE) && !pending && any_free;

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= 1'b0;
      for (int i = 0; i < NumSlots; i++) begin
        bloon_active[i] <= 1'b0;
        bloon_pos[i]    <= '0;
        lost_life[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        lost_life[i] <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (move_tick || pending) begin
            state   <= SWEEP;
            idx     <= '0;
            pending <= 1'b0;
          end
          if (spawn_valid && spawn_ready) begin
            bloon_active[spawn_slot] <= 1'b1;
            bloon_pos[spawn_slot]    <= '0;
          end
        end
        SWEEP: begin
          if (bloon_active[idx] && !pop[idx]) begin
            if (bloon_pos[idx] == ExitPos) begin
              bloon_active[idx] <= 1'b0;
              bloon_pos[idx]    <= '0;
              lost_life[idx]    <= 1'b1;
            end else begin
              bloon_pos[idx] <= bloon_pos[idx] + PosW'(1);
            end
          end
          if (idx == LastIdx) begin
            idx <= '0;
            // A held tick restarts the sweep directly; one arriving now waits in IDLE.
            if (pending) begin
              pending <= 1'b0;
            end else begin
              state   <= IDLE;
              pending <= move_tick;
            end
          end else begin
            idx <= idx + slot_idx_t'(1);
            if (move_tick) begin
              pending <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Pops land last so they override both the sweep update and an exit.
      for (int i = 0; i < NumSlots; i++) begin
        if (pop[i] && bloon_active[i]) begin
          bloon_active[i] <= 1'b0;
          bloon_pos[i]    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bloon_path_walker.sv
// Scoreboard bench for bloon_path_walker on a 4-step track.
module tb_bloon_path_walker;
  import bloons_pkg::*;

  localparam int unsigned PathLen = 4;
  localparam int unsigned N       = NUM_BLOONS;

  logic             Clk = 1'b0;
  logic             reset = 1'b0;
  logic             move_tick = 1'b0;
  logic             spawn_valid = 1'b0;
  logic             spawn_ready;
  slot_idx_t        spawn_slot;
  logic             pop          [N];
  logic             lost_life    [N];
  logic             bloon_active [N];
  logic [POS_W-1:0] bloon_pos    [N];
  logic             busy;

  bloon_path_walker #(
    .NumSlots(N),
    .PathLen (PathLen),
    .PosW    (POS_W)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
    .move_tick   (move_tick),
    .spawn_valid (spawn_valid),
    .spawn_ready (spawn_ready),
    .spawn_slot  (spawn_slot),
    .pop         (pop),
    .lost_life   (lost_life),
    .bloon_active(bloon_active),
    .bloon_pos   (bloon_pos),
    .busy        (busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int lives    = 10;

  typedef struct {int slot; int at;} exit_t;
  exit_t exp_q[$];
  bit    m_active [N];
  int    m_pos    [N];

  // Exit monitor: every pulse must match the head of the scoreboard, one at a time.
  always @(negedge Clk) begin
    int    hi;
    exit_t e;
    hi = 0;
    for (int i = 0; i < N; i++) begin
      if (lost_life[i] === 1'b1) begin
        hi++;
        lives--;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL exit_event: slot %0d pulsed at cycle %0d, no exit expected", i, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.slot != i || e.at != cyc) begin
            n_fail++;
            $display("FAIL exit_event: got slot %0d at cycle %0d, expected slot %0d at cycle %0d",
                     i, cyc, e.slot, e.at);
          end
        end
      end
    end
    if (hi > 0) begin
      n_checks++;
      if (hi != 1) begin
        n_fail++;
        $display("FAIL lost_life_onehot: %0d bits high, expected 1", hi);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    spawn_valid = 1'b0;
    move_tick   = 1'b0;
    for (int i = 0; i < N; i++) pop[i] = 1'b0;
    step();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 1'b0;
      m_pos[i]    = 0;
    end
    lives = 10;
  endtask

  task automatic spawn_n(input int n);
    int exp_slot;
    for (int k = 0; k < n; k++) begin
      exp_slot = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_active[i]) exp_slot = i;
      spawn_valid = 1'b1;
      n_checks += 2;
      if (spawn_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL spawn_ready: got %b, expected 1", spawn_ready);
      end
      if (spawn_slot !== slot_idx_t'(exp_slot)) begin
        n_fail++;
        $display("FAIL spawn_slot: got %0d, expected %0d", spawn_slot, exp_slot);
      end
      step();
      m_active[exp_slot] = 1'b1;
      m_pos[exp_slot]    = 0;
    end
    spawn_valid = 1'b0;
  endtask

  // One movement tick from IDLE; optionally pops pop_slot in the cycle the sweep visits it.
  task automatic tick(input int pop_slot);
    int t;
    t = cyc;
    move_tick = 1'b1;
    for (int s = 0; s < N; s++) begin
      if (m_active[s]) begin
        if (s == pop_slot) begin
          m_active[s] = 1'b0;
          m_pos[s]    = 0;
        end else if (m_pos[s] == PathLen - 1) begin
          exp_q.push_back('{slot: s, at: t + 2 + s});
          m_active[s] = 1'b0;
          m_pos[s]    = 0;
        end else begin
          m_pos[s]++;
        end
      end
    end
    step();
    move_tick = 1'b0;
    if (pop_slot >= 0) begin
      while (cyc < t + 1 + pop_slot) step();
      pop[pop_slot] = 1'b1;
      step();
      pop[pop_slot] = 1'b0;
    end
    while (cyc < t + 40) step();
  endtask

  task automatic test_reset();
    int act_cnt, pos_cnt, lost_cnt;
    do_reset();
    act_cnt = 0; pos_cnt = 0; lost_cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (bloon_active[i] !== 1'b0) act_cnt++;
      if (bloon_pos[i] !== '0) pos_cnt++;
      if (lost_life[i] !== 1'b0) lost_cnt++;
    end
    n_checks += 6;
    if (act_cnt != 0) begin n_fail++; $display("FAIL reset_active: %0d slots set, expected 0", act_cnt); end
    if (pos_cnt != 0) begin n_fail++; $display("FAIL reset_pos: %0d nonzero, expected 0", pos_cnt); end
    if (lost_cnt != 0) begin n_fail++; $display("FAIL reset_lost: %0d set, expected 0", lost_cnt); end
    if (spawn_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1", spawn_ready); end
    if (spawn_slot !== 5'd0) begin n_fail++; $display("FAIL reset_slot: got %0d, expected 0", spawn_slot); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_spawn();
    do_reset();
    spawn_n(3);
    // Spawn into slot 3 while popping slot 1, plus a pop on an empty slot.
    spawn_valid = 1'b1;
    pop[1] = 1'b1;
    pop[7] = 1'b1;
    step();
    spawn_valid = 1'b0;
    pop[1] = 1'b0;
    pop[7] = 1'b0;
    m_active[3] = 1'b1;
    m_active[1] = 1'b0;
    for (int s = 0; s < N; s++) begin
      n_checks += 2;
      if (bloon_active[s] !== m_active[s]) begin
        n_fail++;
        $display("FAIL spawn_active[%0d]: got %b, expected %b", s, bloon_active[s], m_active[s]);
      end
      if (bloon_pos[s] !== POS_W'(m_pos[s])) begin
        n_fail++;
        $display("FAIL spawn_pos[%0d]: got %0d, expected %0d", s, bloon_pos[s], m_pos[s]);
      end
    end
    n_checks++;
    if (spawn_slot !== 5'd1) begin
      n_fail++;
      $display("FAIL spawn_slot_after_pop: got %0d, expected 1", spawn_slot);
    end
  endtask

  task automatic test_exit();
    do_reset();
    spawn_n(1);
    repeat (4) tick(-1);
    n_checks += 3;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL exit_missing: %0d pending, expected 0", exp_q.size()); end
    if (lives != 9) begin n_fail++; $display("FAIL exit_lives: got %0d, expected 9", lives); end
    if (bloon_active[0] !== 1'b0) begin n_fail++; $display("FAIL exit_active: got %b, expected 0", bloon_active[0]); end
  endtask

  task automatic test_serial_exits();
    do_reset();
    spawn_n(6);
    for (int i = 1; i <= 4; i++) begin
      pop[i] = 1'b1;
      m_active[i] = 1'b0;
    end
    step();
    for (int i = 1; i <= 4; i++) pop[i] = 1'b0;
    repeat (4) tick(-1);
    n_checks += 3;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL serial_missing: %0d pending, expected 0", exp_q.size()); end
    if (lives != 8) begin n_fail++; $display("FAIL serial_lives: got %0d, expected 8", lives); end
    if (bloon_active[5] !== 1'b0) begin n_fail++; $display("FAIL serial_active5: got %b, expected 0", bloon_active[5]); end
  endtask

  task automatic test_pop_at_exit();
    do_reset();
    spawn_n(1);
    repeat (3) tick(-1);
    n_checks++;
    if (bloon_pos[0] !== POS_W'(PathLen - 1)) begin
      n_fail++;
      $display("FAIL pop_exit_prepos: got %0d, expected %0d", bloon_pos[0], PathLen - 1);
    end
    tick(0);
    n_checks += 2;
    if (bloon_active[0] !== 1'b0) begin n_fail++; $display("FAIL pop_exit_active: got %b, expected 0", bloon_active[0]); end
    if (lives != 10) begin n_fail++; $display("FAIL pop_exit_lives: got %0d, expected 10", lives); end
  endtask

  task automatic test_reset_mid_sweep();
    do_reset();
    spawn_n(1);
    repeat (3) tick(-1);
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    repeat (40) step();
    n_checks += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
    if (bloon_active[0] !== 1'b0) begin n_fail++; $display("FAIL midreset_active: got %b, expected 0", bloon_active[0]); end
    if (lives != 10) begin n_fail++; $display("FAIL midreset_lives: got %0d, expected 10", lives); end
  endtask

  task automatic test_tick_overlap(input int n_extra);
    int cnt, ready_seen, act_cnt;
    do_reset();
    spawn_n(1);
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
    spawn_valid = 1'b1;
    cnt = 0;
    ready_seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge Clk);
      if (busy !== 1'b1) break;
      cnt++;
      if (spawn_ready !== 1'b0) ready_seen++;
      move_tick = (cnt == 4) || (n_extra > 1 && cnt == 10);
    end
    spawn_valid = 1'b0;
    move_tick   = 1'b0;
    step();
    act_cnt = 0;
    for (int i = 0; i < N; i++) if (bloon_active[i] === 1'b1) act_cnt++;
    n_checks += 4;
    if (cnt != 64) begin n_fail++; $display("FAIL overlap_busy_len(%0d): got %0d, expected 64", n_extra, cnt); end
    if (ready_seen != 0) begin n_fail++; $display("FAIL overlap_ready(%0d): high %0d cycles, expected 0", n_extra, ready_seen); end
    if (act_cnt != 1) begin n_fail++; $display("FAIL overlap_spawned(%0d): %0d active, expected 1", n_extra, act_cnt); end
    if (bloon_pos[0] !== POS_W'(2)) begin n_fail++; $display("FAIL overlap_pos(%0d): got %0d, expected 2", n_extra, bloon_pos[0]); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) pop[i] = 1'b0;
    test_reset();
    test_spawn();
    test_exit();
    test_serial_exits();
    test_pop_at_exit();
    test_reset_mid_sweep();
    test_tick_overlap(1);
    test_tick_overlap(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/bloon_path_walker.md
Name: bloon_path_walker

Overview:
- Owns the 32 bloon slots and advances each live bloon along the track on every movement tick.
- Drives the per-slot `lost_life` flags that `life_counter` consumes.
- Serialises track-exit events so at most one `lost_life` bit rises per clock, which keeps `life_counter`'s per-cycle decrement exact.
- Sits between the wave spawner (spawn handshake), dart/collision logic (`pop`) and `life_counter`/renderer (`lost_life`, positions).

Parameters:
- NUM_BLOONS, 32, number of bloon slots; must match `life_counter` width.
- PATH_LEN, 640, track length in steps; position PATH_LEN-1 is the exit.
- POS_W, 10, position width; PATH_LEN <= 2**POS_W is required.

Ports:
- Clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- move_tick  in  1  one-cycle pulse: advance all bloons by one step.
- spawn_valid  in  1  spawner requests a new bloon.
- spawn_ready  out  1  a free slot exists and FSM is IDLE.
- spawn_slot  out  5  index of the lowest free slot; meaningful while spawn_ready=1.
- pop  in  1 x NUM_BLOONS (unpacked)  level; kill bloon i this cycle.
- lost_life  out  1 x NUM_BLOONS (unpacked)  registered; bit i high one cycle when bloon i exits.
- bloon_active  out  1 x NUM_BLOONS (unpacked)  slot occupied.
- bloon_pos  out  POS_W x NUM_BLOONS (unpacked)  current step of each slot.
- busy  out  1  FSM in SWEEP.

Behaviour:
- Reset (reset=0 at a Clk edge):
  - All bloon_active=0, bloon_pos=0, lost_life=0.
  - FSM=IDLE, idx=0, pending=0.
  - Reset mid-sweep aborts the sweep and drops any pending tick; no lost_life pulse follows.
- FSM states: IDLE, SWEEP.
  - IDLE --move_tick or pending--> SWEEP, with idx<=0 and pending<=0.
  - SWEEP: processes slot idx each cycle; idx==NUM_BLOONS-1 --> IDLE, or back to SWEEP with idx=0 if pending.
  - A sweep is exactly NUM_BLOONS cycles.
- Per-slot processing in SWEEP, slot idx, if active and pop[idx]=0:
  - pos==PATH_LEN-1: active<=0, pos<=0, lost_life[idx]<=1.
  - else: pos<=pos+1.
- lost_life:
  - Every bit defaults to 0 each cycle, so each pulse is exactly one cycle wide.
  - At most one bit is high in any cycle.
  - The pulse appears the cycle after slot idx is processed, i.e. idx+2 cycles after the move_tick sample edge when starting from IDLE.
- move_tick during SWEEP sets pending=1. Further ticks while pending=1 are dropped (one-deep).
- Spawn:
  - spawn_ready = IDLE and no pending tick and any slot inactive.
  - spawn_slot = lowest-index inactive slot (priority encoder).
  - spawn_valid && spawn_ready: slot active<=1, pos<=0 next cycle.
  - Only one spawn per cycle.
  - spawn_valid while spawn_ready=0 is ignored; the spawner holds the request.
- Pop:
  - pop[i] && active[i]: active<=0, pos<=0 next cycle, in any state.
  - Pop beats exit: a popped bloon at the exit step produces no lost_life.
  - pop on an inactive slot has no effect.
- Simultaneous events:
  - Spawn and pop in the same IDLE cycle both take effect.
  - Spawn cannot target a slot being popped, because that slot is still active that cycle.
- Width: pos increments by 1 and never exceeds PATH_LEN-1; no wrap.

Decomposition:
- Shared package `bloons_pkg`:
  - NUM_BLOONS, PATH_LEN, POS_W.
  - walker_state_t enum {IDLE, SWEEP}.
  - slot_idx_t (logic [4:0]).
  - This package is shared with life_counter and the renderer.
- One sub-module: `free_slot_encoder` (combinational lowest-zero priority encoder over bloon_active → spawn_slot, any_free).

Test Plan:
- Reset low 2 cycles then high → all outputs 0, spawn_ready=1, spawn_slot=0, busy=0.
- Three back-to-back spawns in IDLE → slots 0,1,2 active with pos 0; spawn_slot then reads 3.
- Exit (PATH_LEN=4): spawn one bloon, issue 4 ticks 40 cycles apart → lost_life[0] high for exactly 1 cycle, 2 cycles after the 4th tick, then active[0]=0. Attached life_counter goes 10→9.
- Serialised exits (PATH_LEN=4): bloons in slots 0 and 5 reach the exit in the same sweep → two pulses 5 cycles apart, never both high; life_counter goes 10→8.
- Pop at pos=PATH_LEN-1 in the same cycle as its sweep slot → no lost_life, active cleared.
- Tick overlap: tick at sweep cycle 3 → busy stays high for 64 cycles total. Two ticks inside one sweep → still only 64 cycles. Spawn_ready=0 and spawn_valid ignored throughout.
